ibex_branch_predict_ctrl: RTL
=============================

Name: ibex_branch_predict_ctrl

Overview:
Sequences the static branch predictor between the fetch stage and the execute stage.
- Accepts each prediction made for a fetched branch or jump.
- Issues a registered redirect to the prefetch buffer when the prediction is taken.
- Queues outstanding predictions in order and checks each against the resolved outcome from EX.
- On a misprediction, raises a recovery redirect and blocks new predictions until the core controller acknowledges the flush.

Parameters:
DEPTH, 2, number of outstanding predictions tracked (power of two, 2..8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pred_valid_i  in  1  fetch presents a branch/jump with a prediction this cycle
pred_ready_o  out  1  controller can accept a prediction
pred_taken_i  in  1  predictor says taken
pred_target_i  in  32  predicted target PC
pred_instr_pc_i  in  32  PC of the predicted instruction
pred_compressed_i  in  1  instruction is 16-bit
redirect_o  out  1  one-cycle pulse: prefetch must fetch from redirect_pc_o
redirect_pc_o  out  32  redirect address
res_valid_i  in  1  EX resolves the oldest outstanding branch/jump
res_taken_i  in  1  actual direction
res_target_i  in  32  actual taken target
mispredict_o  out  1  one-cycle pulse on detected misprediction
flush_ack_i  in  1  core controller has flushed IF/ID
busy_o  out  1  queue non-empty or in RECOVER state

Behaviour:
- Reset state:
  - All outputs 0.
  - FSM in RUN.
  - Queue empty; read/write pointers 0.
  - pred_ready_o = 1 one cycle after reset deassertion. It is 0 while rst_ni is low.
- Accepting a prediction:
  - Accept when pred_valid_i & pred_ready_o.
  - Push the entry {taken, target, fallthrough}, where fallthrough = pred_instr_pc_i + (pred_compressed_i ? 2 : 4). Addition is mod 2^32; wrap is allowed.
- Predicted-taken redirect:
  - On an accepted taken prediction, the next cycle has redirect_o=1 and redirect_pc_o=pred_target_i.
  - Latency is exactly 1. The redirect is registered, not combinational.
- pred_ready_o = (state==RUN) & !full.
  - A full queue with a simultaneous resolve still gives ready=0. There is no bypass.
- Resolution:
  - res_valid_i with an empty queue is illegal; assert against it. The controller ignores it.
  - Otherwise pop the head and compare:
    - mispredict = (res_taken_i != head.taken) | (res_taken_i & head.taken & res_target_i != head.target).
    - Correct prediction: pop only.
    - Mispredict: the next cycle has mispredict_o=1, redirect_o=1, and redirect_pc_o = res_taken_i ? res_target_i : head.fallthrough. The entire queue is cleared, the FSM goes to RECOVER, and pred_ready_o=0.
- FSM:
  - RUN -> RECOVER on mispredict.
  - RECOVER -> RUN on flush_ack_i. Ready returns the following cycle.
  - flush_ack_i in RUN is ignored.
- Simultaneous push and resolve in the same cycle:
  - Correct resolve: both happen and the occupancy count is unchanged.
  - Mispredict: the push is discarded, since the younger instruction is wrong-path. The mispredict redirect wins over the taken-prediction redirect.
- Redirect priority within one cycle: mispredict redirect > prediction redirect. At most one redirect pulse per cycle.
- Pointers wrap modulo DEPTH. Full/empty are derived from an extra wrap bit.
- busy_o = !empty | (state==RECOVER).
- Asynchronous reset mid-operation returns everything to the reset state immediately. Pending redirects are dropped.

Optional Feature:
IBEX_BP_PERF_COUNTERS_EN
- Defined: adds outputs perf_pred_cnt_o[31:0] (count of accepted predictions) and perf_mispred_cnt_o[31:0] (count of mispredicts). Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Taken redirect: push taken, target 0x0000_1000, pc 0x80 -> next cycle redirect_o=1, redirect_pc_o=0x1000. Resolve taken, target 0x1000 -> no mispredict, busy_o=0.
- Direction mispredict, uncompressed: push not-taken, pc 0x200, compressed 0. Resolve taken, target 0x300 -> mispredict_o=1, redirect_pc_o=0x300, RECOVER, pred_ready_o=0. flush_ack_i -> ready=1 the next cycle.
- Fallthrough recovery, compressed: push taken, pc 0x400, compressed 1. Resolve not-taken -> redirect_pc_o=0x402. Also pc 0xFFFF_FFFE compressed -> fallthrough 0x0000_0000.
- Full queue: DEPTH=2, push 2 correct predictions -> pred_ready_o=0. A simultaneous push and correct resolve keep ready 0 that cycle; ready=1 after the resolve.
- Mispredict during simultaneous push: push taken 0x900 while resolving the head as a mispredict -> single redirect to the correct PC, queue empty, no 0x900 redirect.
- Reset and counters: assert rst_ni mid-RECOVER -> all outputs 0, ready=1 after release. With IBEX_BP_PERF_COUNTERS_EN, 3 predictions and 1 mispredict -> counts 3/1.

Source files
------------

// File: rtl/ibex_branch_predict_ctrl.sv
// ibex_branch_predict_ctrl: tracks static branch predictions from IF, redirects on taken, recovers on EX mispredicts.
// Optional IBEX_BP_PERF_COUNTERS_EN adds saturating prediction/mispredict counters.
module ibex_branch_predict_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pred_valid_i,
    output logic        pred_ready_o,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    input  logic [31:0] pred_instr_pc_i,
    input  logic        pred_compressed_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    output logic        mispredict_o,
    input  logic        flush_ack_i,
`ifdef IBEX_BP_PERF_COUNTERS_EN
    output logic [31:0] perf_pred_cnt_o,
    output logic [31:0] perf_mispred_cnt_o,
`endif
    output logic        busy_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;
    typedef enum logic {RUN, RECOVER} state_e;
    state_e state_q;
    logic [AW:0] wptr_q, rptr_q;
    logic [DEPTH-1:0] taken_q;
    logic [31:0] target_q [DEPTH];
    logic [31:0] fall_q [DEPTH];
    logic rdy_q;
    logic empty, full, push, res_fire, mis, h_taken;
    logic [31:0] h_target, h_fall, fallthrough;
    assign empty = wptr_q == rptr_q;
    assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pred_ready_o = rdy_q && state_q == RUN && !full;
    assign busy_o = !empty || state_q == RECOVER;
    assign push = pred_valid_i && pred_ready_o;
    assign res_fire = res_valid_i && !empty;
    assign h_taken = taken_q[rptr_q[AW-1:0]];
    assign h_target = target_q[rptr_q[AW-1:0]];
    assign h_fall = fall_q[rptr_q[AW-1:0]];
    assign mis = res_fire && ((res_taken_i != h_taken) || (res_taken_i && h_taken && res_target_i != h_target));
    assign fallthrough = pred_instr_pc_i + (pred_compressed_i ? 32'd2 : 32'd4);
    always_ff @(posedge clk_i) begin
        if (push) begin
            taken_q[wptr_q[AW-1:0]] <= pred_taken_i;
            target_q[wptr_q[AW-1:0]] <= pred_target_i;
            fall_q[wptr_q[AW-1:0]] <= fallthrough;
        end
    end
    // A mispredict flushes the whole queue, including any same-cycle (wrong-path) push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            wptr_q <= '0;
            rptr_q <= '0;
            rdy_q <= 1'b0;
            redirect_o <= 1'b0;
            redirect_pc_o <= '0;
            mispredict_o <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            mispredict_o <= mis;
            redirect_o <= mis || (push && pred_taken_i);
            if (mis)
                redirect_pc_o <= res_taken_i ? res_target_i : h_fall;
            else if (push && pred_taken_i)
                redirect_pc_o <= pred_target_i;
            if (mis) begin
                wptr_q <= '0;
                rptr_q <= '0;
                state_q <= RECOVER;
            end else begin
                if (push) wptr_q <= wptr_q + PTR_ONE;
                if (res_fire) rptr_q <= rptr_q + PTR_ONE;
                if (state_q == RECOVER && flush_ack_i) state_q <= RUN;
            end
        end
    end
`ifdef IBEX_BP_PERF_COUNTERS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_pred_cnt_o <= '0;
            perf_mispred_cnt_o <= '0;
        end else begin
            if (push && perf_pred_cnt_o != '1) perf_pred_cnt_o <= perf_pred_cnt_o + 32'd1;
            if (mis && perf_mispred_cnt_o != '1) perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
        end
    end
`endif
    a_res_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(res_valid_i && empty));
endmodule
